// File: rtl/reg_file.sv
// 32 x DATA_W register file: one-hot write select, two registered read ports with
// write-first forwarding, hard-wired zero register and multi-hot write rejection.
module reg_file #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [4:0]        rd_addr_a,
    input  logic [4:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              wr_err,
    output logic [4:0]        wr_last
);

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;
    logic              err_q, err_d;
    logic [4:0]        last_q, last_d;

    logic              sel_onehot;
    logic              sel_multi;
    logic              wr_valid;
    logic [4:0]        wr_idx;

    // A power of two has no bits in common with itself minus one.
    assign sel_onehot = (wr_sel != 32'd0) && ((wr_sel & (wr_sel - 32'd1)) == 32'd0);
    assign sel_multi  = (wr_sel != 32'd0) && !sel_onehot;
    assign wr_valid   = sel_onehot && !wr_sel[0];

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (wr_sel[i]) begin
                wr_idx = wr_idx | 5'(i);
            end
        end
    end

    always_comb begin
        rd_a_d = regs_q[rd_addr_a];
        rd_b_d = regs_q[rd_addr_b];
        if (wr_valid && (wr_idx == rd_addr_a)) begin
            rd_a_d = wr_data;
        end
        if (wr_valid && (wr_idx == rd_addr_b)) begin
            rd_b_d = wr_data;
        end
        if (rd_addr_a == 5'd0) begin
            rd_a_d = '0;
        end
        if (rd_addr_b == 5'd0) begin
            rd_b_d = '0;
        end
        err_d  = sel_multi;
        last_d = wr_valid ? wr_idx : last_q;
    end

    // NOTE: the storage array is reset along with the control state because its
    // contents must read back as zero after any reset, not merely the first.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            rd_a_q <= '0;
            rd_b_q <= '0;
            err_q  <= 1'b0;
            last_q <= 5'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (wr_valid) begin
                regs_q[wr_idx] <= wr_data;
            end
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
            err_q  <= err_d;
            last_q <= last_d;
        end
    end

    assign rd_data_a = rd_a_q;
    assign rd_data_b = rd_b_q;
    assign wr_err    = err_q;
    assign wr_last   = last_q;

endmodule
